ysyx_2022040010_regfile_sb: RTL and testbench
=============================================

YSYX_2022040010_REGFILE_SB -- requirements
Module: ysyx_2022040010_regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 64: register data width in bits.
REQ-002 SHALL have parameter NREG, default 32: number of architectural registers, a power of two >= 2; AW = log2(NREG).
REQ-003 SHALL have parameter NRD, default 2: number of read ports, 1..4.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on posedge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port stall, input, 1: writeback hold; a write is suppressed while this is 1.
REQ-007 SHALL have port we, input, 1: write enable.
REQ-008 SHALL have port waddr, input, AW: write register index.
REQ-009 SHALL have port wdata, input, XLEN: write data.
REQ-010 SHALL have port re, input, NRD: per-port read enable.
REQ-011 SHALL have port raddr, input, NRD*AW: port i index at bits [i*AW +: AW].
REQ-012 SHALL have port rdata, output, NRD*XLEN: port i data at bits [i*XLEN +: XLEN].
REQ-013 SHALL have port alloc_en, input, 1: an issued instruction will write alloc_addr.
REQ-014 SHALL have port alloc_addr, input, AW: destination index being allocated.
REQ-015 SHALL have port flush, input, 1: pipeline flush; clears all pending marks.
REQ-016 SHALL have port hazard, output, NRD: port i reads a register whose producer has not committed.
REQ-017 SHALL have port busy_cnt, output, AW+1: number of registers currently marked busy.

Function
REQ-018 SHALL commit a write when we=1, stall=0 and waddr!=0; regs[waddr] takes wdata at the posedge.
REQ-019 SHALL keep register 0 reading zero; writes to index 0 are discarded.
REQ-020 SHALL drive each rdata port combinationally: 0 if re[i]=0 or raddr_i=0; else wdata if the port's address matches a committing write in the same cycle (bypass); else regs[raddr_i].
REQ-021 SHALL exclude a stalled write (stall=1) from the bypass.
REQ-022 SHALL keep a busy bit per register: set at posedge by alloc_en=1 with alloc_addr!=0; cleared at posedge by a committing write to that index.
REQ-023 SHALL give set priority when an allocation and a commit target the same index in one cycle; the bit stays 1 (newer producer).
REQ-024 SHALL clear all busy bits on flush=1 at the posedge, with priority over alloc_en and commits; register data still commits.
REQ-025 SHALL assert hazard[i] = re[i] & (raddr_i!=0) & busy[raddr_i] & no committing write to raddr_i in that cycle.
REQ-026 SHALL keep busy[0] permanently 0.
REQ-027 SHALL register busy_cnt, equal to the population count of the busy bits after each posedge update, ranging 0..NREG-1.
REQ-028 SHALL have zero-cycle read latency and one-cycle write-to-array latency.

Reset
REQ-029 SHALL, while rst=1, asynchronously clear all registers to 0, all busy bits to 0 and busy_cnt to 0.
REQ-030 SHALL drive rdata to 0 and hazard to 0 while rst=1.
REQ-031 SHALL abandon any write or allocation coinciding with reset assertion.

Configuration
REQ-032 SHALL, when macro YSYX_2022040010_REGFILE_DIFFTEST_EN is defined, add output regs_flat (NREG*XLEN), where entry r equals wdata if a write to r commits this cycle and r!=0, else regs[r].
REQ-033 SHALL, when the macro is undefined, omit regs_flat and leave all other behaviour unchanged.

Verification
REQ-034 SHALL verify reset mid-operation: write x5=0xDEAD, then pulse rst asynchronously between edges -> rdata for x5=0 immediately; busy_cnt=0.
REQ-035 SHALL verify bypass: commit x7=0x1234 while reading x7 on every port in the same cycle -> all ports=0x1234; with stall=1 -> old x7 value.
REQ-036 SHALL verify the scoreboard: alloc x3; next cycle read x3 -> hazard=1, busy_cnt=1; commit x3=0x55 -> hazard=0 that cycle, busy_cnt=0 after the edge.
REQ-037 SHALL verify simultaneous alloc and commit on x9 -> busy[9] stays 1; with flush in the same cycle -> busy_cnt=0 and x9 data updated.
REQ-038 SHALL verify x0: write 0xFFFF to x0 and alloc x0 -> reads 0, hazard 0, busy_cnt unchanged.
REQ-039 SHALL run with XLEN=32, NREG=16, NRD=3 and the difftest macro on -> regs_flat entry 5 shows the committing wdata in the same cycle.

Source files
------------

// File: rtl/ysyx_2022040010_regfile_sb.sv
// ysyx_2022040010_regfile_sb: register file with write bypass and busy-bit scoreboard.
// Define YSYX_2022040010_REGFILE_DIFFTEST_EN to expose regs_flat for difftest.
module ysyx_2022040010_regfile_sb #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int NRD = 2,
    localparam int AW = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [XLEN-1:0]      wdata,
    input  logic [NRD-1:0]       re,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*XLEN-1:0]  rdata,
    input  logic                 alloc_en,
    input  logic [AW-1:0]        alloc_addr,
    input  logic                 flush,
    output logic [NRD-1:0]       hazard,
    output logic [AW:0]          busy_cnt
`ifdef YSYX_2022040010_REGFILE_DIFFTEST_EN
    ,
    output logic [NREG*XLEN-1:0] regs_flat
`endif
);
    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy, busy_nx;
    logic [AW:0]     cnt_nx;
    logic            commit;

    assign commit = ~rst & we & ~stall & (waddr != '0);

    // set beats commit (newer producer); flush beats both
    always_comb begin
        busy_nx = '0;
        cnt_nx = '0;
        for (int r = 1; r < NREG; r++) begin
            busy_nx[r] = ~flush & ((alloc_en & (alloc_addr == AW'(r))) | (busy[r] & ~(commit & (waddr == AW'(r)))));
            cnt_nx = cnt_nx + {{AW{1'b0}}, busy_nx[r]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
            busy_cnt <= '0;
            for (int r = 0; r < NREG; r++) regs[r] <= '0;
        end else begin
            busy <= busy_nx;
            busy_cnt <= cnt_nx;
            if (commit) regs[waddr] <= wdata;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] ra;
        logic          hit;
        assign ra = raddr[i*AW +: AW];
        assign hit = commit & (waddr == ra);
        assign rdata[i*XLEN +: XLEN] = (rst | ~re[i] | (ra == '0)) ? '0 : hit ? wdata : regs[ra];
        assign hazard[i] = ~rst & re[i] & (ra != '0) & busy[ra] & ~hit;
    end

`ifdef YSYX_2022040010_REGFILE_DIFFTEST_EN
    for (genvar r = 0; r < NREG; r++) begin : g_flat
        assign regs_flat[r*XLEN +: XLEN] = (commit & (waddr == AW'(r))) ? wdata : regs[r];
    end
`endif
endmodule

// File: tb/tb_ysyx_2022040010_regfile_sb.sv
// tb_ysyx_2022040010_regfile_sb: scoreboard bench with directed and random stimulus
// against an array-based reference model of the register file and busy bits.
module tb_ysyx_2022040010_regfile_sb;
    localparam int XLEN = 32, NREG = 16, NRD = 3, AW = 4;

    logic                clk = 0, rst = 1, stall = 0, we = 0, alloc_en = 0, flush = 0;
    logic [AW-1:0]       waddr = '0, alloc_addr = '0;
    logic [XLEN-1:0]     wdata = '0;
    logic [NRD-1:0]      re = '0;
    logic [NRD*AW-1:0]   raddr = '0;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      hazard;
    logic [AW:0]         busy_cnt;
`ifdef YSYX_2022040010_REGFILE_DIFFTEST_EN
    logic [NREG*XLEN-1:0] regs_flat;
`endif

    ysyx_2022040010_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
        .clk(clk), .rst(rst), .stall(stall), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata), .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .flush(flush), .hazard(hazard), .busy_cnt(busy_cnt)
`ifdef YSYX_2022040010_REGFILE_DIFFTEST_EN
        , .regs_flat(regs_flat)
`endif
    );

    typedef struct {
        string               nm;
        logic [NRD*XLEN-1:0] rd;
        logic [NRD-1:0]      hz;
        logic [AW:0]         cnt;
        logic [XLEN-1:0]     f5;
    } exp_t;

    exp_t            q[$];
    logic [XLEN-1:0] m_regs [NREG];
    bit              m_busy [NREG];
    int              checks = 0, errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    function automatic int m_cnt();
        int c = 0;
        for (int r = 0; r < NREG; r++) c += int'(m_busy[r]);
        return c;
    endfunction

    task automatic m_clear_busy();
        for (int r = 0; r < NREG; r++) m_busy[r] = 0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({e.nm, ".rdata"}, 128'(rdata), 128'(e.rd));
            chk({e.nm, ".hazard"}, 128'(hazard), 128'(e.hz));
            chk({e.nm, ".busy_cnt"}, 128'(busy_cnt), 128'(e.cnt));
`ifdef YSYX_2022040010_REGFILE_DIFFTEST_EN
            chk({e.nm, ".flat5"}, 128'(regs_flat[5*XLEN +: XLEN]), 128'(e.f5));
`endif
        end
    end

    task automatic step(input bit w, input int wa, input logic [XLEN-1:0] wd, input bit st,
                        input logic [NRD-1:0] r, input int a0, input int a1, input int a2,
                        input bit al, input int aa, input bit fl, input string nm);
        int   ra[NRD];
        exp_t e;
        bit   cm;
        ra = '{a0, a1, a2};
        we = w; waddr = AW'(wa); wdata = wd; stall = st; re = r;
        raddr = {AW'(a2), AW'(a1), AW'(a0)};
        alloc_en = al; alloc_addr = AW'(aa); flush = fl;
        cm = w && !st && wa != 0;
        e.nm = nm; e.rd = '0; e.hz = '0;
        for (int i = 0; i < NRD; i++)
            if (r[i] && ra[i] != 0) begin
                e.rd[i*XLEN +: XLEN] = (cm && ra[i] == wa) ? wd : m_regs[ra[i]];
                e.hz[i] = m_busy[ra[i]] && !(cm && ra[i] == wa);
            end
        e.cnt = (AW+1)'(m_cnt());
        e.f5 = (cm && wa == 5) ? wd : m_regs[5];
        q.push_back(e);
        @(posedge clk);
        if (cm) m_regs[wa] = wd;
        if (fl) m_clear_busy();
        else begin
            if (cm) m_busy[wa] = 0;
            if (al && aa != 0) m_busy[aa] = 1;
        end
        #1;
    endtask

    task automatic reset_pulse(input string nm);
        exp_t e;
        rst = 1; we = 1; waddr = 5; wdata = 'hBEEF; stall = 0; re = '1;
        raddr = {3{4'd5}}; alloc_en = 1; alloc_addr = 5; flush = 0;
        e.nm = nm; e.rd = '0; e.hz = '0; e.cnt = '0; e.f5 = '0;
        q.push_back(e);
        @(negedge clk);
        #1;
        rst = 0;
        we = 0; re = '0; alloc_en = 0;
        for (int r = 0; r < NREG; r++) m_regs[r] = '0;
        m_clear_busy();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_pulse("reset");
        step(1, 5, 'hDEAD, 0, 3'b000, 0, 0, 0, 1, 3, 0, "w5");
        step(0, 0, 0, 0, 3'b011, 5, 3, 0, 0, 0, 0, "rd5");
        reset_pulse("midrst");
        step(0, 0, 0, 0, 3'b111, 5, 3, 5, 0, 0, 0, "after_rst");
        step(1, 7, 'h1111, 0, 3'b000, 0, 0, 0, 0, 0, 0, "w7");
        step(1, 7, 'h1234, 0, 3'b111, 7, 7, 7, 0, 0, 0, "bypass");
        step(1, 7, 'h5678, 1, 3'b111, 7, 7, 7, 0, 0, 0, "stall_byp");
        step(0, 0, 0, 0, 3'b111, 7, 7, 7, 0, 0, 0, "rd7");
        step(0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 3, 0, "alloc3");
        step(0, 0, 0, 0, 3'b001, 3, 0, 0, 0, 0, 0, "haz3");
        step(1, 3, 'h55, 0, 3'b111, 3, 3, 3, 0, 0, 0, "commit3");
        step(0, 0, 0, 0, 3'b001, 3, 0, 0, 0, 0, 0, "cnt0");
        step(0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 9, 0, "alloc9");
        step(1, 9, 'hAA, 0, 3'b100, 0, 0, 9, 1, 9, 0, "alloc_commit9");
        step(0, 0, 0, 0, 3'b100, 0, 0, 9, 0, 0, 0, "busy9");
        step(1, 9, 'hBB, 0, 3'b000, 0, 0, 0, 1, 9, 1, "flush9");
        step(0, 0, 0, 0, 3'b010, 0, 9, 0, 1, 4, 0, "rd9");
        step(1, 0, 'hFFFF, 0, 3'b111, 0, 0, 4, 1, 0, 0, "x0");
        step(0, 0, 0, 0, 3'b111, 0, 4, 0, 0, 0, 0, "x0_after");
        step(1, 5, 'hCAFE, 0, 3'b001, 5, 0, 0, 0, 0, 0, "flat5");
        repeat (300)
            step($urandom_range(0, 1) == 1, int'($urandom_range(0, NREG-1)), $urandom,
                 $urandom_range(0, 3) == 0, NRD'($urandom),
                 int'($urandom_range(0, NREG-1)), int'($urandom_range(0, NREG-1)),
                 int'($urandom_range(0, NREG-1)), $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, NREG-1)), $urandom_range(0, 15) == 0, "rnd");
        for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
